// File: rtl/vdff_stim_gen.sv
// vdff_stim_gen: burst pattern generator feeding vdff.in.
// Emits burst_len words of a counter, walking-one, LFSR or checkerboard pattern
// on start, with pause support and a one-cycle done pulse.
// Optional feature macro: STIM_GEN_LFSR_EN (mode 2 = LFSR; otherwise mode 2 = counter).
module vdff_stim_gen #(
    parameter int unsigned     size  = 5,
    parameter int unsigned     len_w = 8,
    parameter int unsigned     seed  = 1,
    parameter logic [size-1:0] taps  = 5'b10100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [len_w-1:0] burst_len,
    input  logic             pause,
    output logic [size-1:0]  data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [len_w-1:0]   rem, rem_d;
    logic [size-1:0]    data_d;
    logic               valid_d, busy_d, done_d;

`ifndef STIM_GEN_LFSR_EN
    // LFSR parameters have no function without the LFSR feature.
    logic unused_lfsr_cfg;
    assign unused_lfsr_cfg = ^{size'(seed), taps};
`endif

    // First word of a burst for the given pattern mode.
    function automatic logic [size-1:0] first_word(input logic [1:0] m);
        logic [size-1:0] w;
        w = '0;
        case (m)
            2'd1: w = size'(1);
`ifdef STIM_GEN_LFSR_EN
            2'd2: w = size'(seed);
`endif
            2'd3: begin
                for (int i = 0; i < int'(size); i++) begin
                    w[i] = ~i[0];
                end
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    // Successor of word d for the given pattern mode.
    function automatic logic [size-1:0] next_word(input logic [1:0] m,
                                                  input logic [size-1:0] d);
        logic [size-1:0] w;
        case (m)
            2'd1: w = {d[size-2:0], d[size-1]};
`ifdef STIM_GEN_LFSR_EN
            2'd2: w = {d[size-2:0], ^(d & taps)};
`endif
            2'd3: w = ~d;
            default: w = d + size'(1);
        endcase
        return w;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= 2'd0;
            rem        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            mode_q     <= mode_d;
            rem        <= rem_d;
            data_out   <= data_d;
            data_valid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        rem_d   = rem;
        data_d  = data_out;
        valid_d = data_valid;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    mode_d = mode;
                    rem_d  = burst_len;
                    if (burst_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        data_d  = first_word(mode);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rem == len_w'(1)) begin
                    // Last word already on data_out; pause cannot delay completion.
                    state_d = DONE;
                    rem_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (pause) begin
                    state_d = PAUSED;
                    valid_d = 1'b0;
                end else begin
                    data_d  = next_word(mode_q, data_out);
                    rem_d   = rem - len_w'(1);
                    valid_d = 1'b1;
                end
            end
            PAUSED: begin
                valid_d = 1'b0;
                if (!pause) begin
                    // Paused word was already counted; resume with its successor.
                    state_d = RUN;
                    data_d  = next_word(mode_q, data_out);
                    rem_d   = rem - len_w'(1);
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
